// File: rtl/onehot_seq_fsm_if.sv
// Handshake/data bundle for the one-hot sequencing FSM.
// The controller side drives run/restart and the two condition words.
// The FSM side returns the working registers, the state vector and the error pulse.
interface onehot_seq_fsm_if #(
    parameter int WIDTH = 8,
    parameter int NS    = 16
);
    logic             run;
    logic             restart;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic [NS-1:0]    state_o;
    logic             err;

    modport master (
        output run, restart, a, b,
        input  x, y, state_o, err
    );

    modport slave (
        input  run, restart, a, b,
        output x, y, state_o, err
    );
endinterface

// File: rtl/onehot_seq_fsm.sv
// One-hot sequencing FSM with two WIDTH-bit working registers X and Y.
// After INIT the machine circles A-chain -> CHK_A -> B-chain -> CHK_B -> C-chain.
// CHK_A may decrement Y and jump back to loop entry.
// CHK_B may increment X and jump back to loop entry.
// Any state vector that is not exactly one-hot is steered back to INIT with a one-cycle err pulse.
module onehot_seq_fsm #(
    parameter int               WIDTH    = 8,
    parameter int               DLY_A    = 6,
    parameter int               DLY_B    = 3,
    parameter int               DLY_C    = 4,
    parameter logic [WIDTH-1:0] X_INIT   = WIDTH'(20),
    parameter logic [WIDTH-1:0] Y_INIT   = WIDTH'(100),
    parameter bit               SATURATE = 1'b1,
    localparam int              NS       = DLY_A + DLY_B + DLY_C + 3
) (
    input  logic             clk,
    input  logic             resetb,
    onehot_seq_fsm_if.slave  bus
);

    // Bit positions of the named states in the one-hot vector.
    localparam int S_INIT  = 0;
    localparam int S_A1    = 1;
    localparam int S_CHKA  = DLY_A + 1;
    localparam int S_B1    = DLY_A + 2;
    localparam int S_CHKB  = DLY_A + DLY_B + 2;
    localparam int S_C1    = DLY_A + DLY_B + 3;
    localparam int S_CLAST = NS - 1;

    localparam logic [NS-1:0] INIT_VEC = NS'(1) << S_INIT;

    logic [NS-1:0]    r_state;
    logic [WIDTH-1:0] r_x;
    logic [WIDTH-1:0] r_y;
    logic             r_err;

    logic [NS-1:0]    w_state_next;
    logic [WIDTH-1:0] w_x_next;
    logic [WIDTH-1:0] w_y_next;
    logic             w_err_next;
    logic             w_legal;
    logic             w_dec;
    logic             w_inc;
    logic [WIDTH-1:0] w_y_dec;
    logic [WIDTH-1:0] w_x_inc;

    assign w_legal = $onehot(r_state);
    assign w_dec   = (bus.a == WIDTH'(1));
    assign w_inc   = (bus.b == WIDTH'(1));

    // Saturating mode pins Y at zero and X at all-ones; otherwise plain modulo wrap.
    assign w_y_dec = (SATURATE && (r_y == '0)) ? r_y : r_y - WIDTH'(1);
    assign w_x_inc = (SATURATE && (&r_x))      ? r_x : r_x + WIDTH'(1);

    // State, working registers and err all register here; reset dominates everything.
    always_ff @(posedge clk) begin
        if (!resetb) begin
            r_state <= INIT_VEC;
            r_x     <= '0;
            r_y     <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_x     <= w_x_next;
            r_y     <= w_y_next;
            r_err   <= w_err_next;
        end
    end

    // Next-state: restart beats illegal-state recovery, which beats the run/hold gate.
    always_comb begin
        w_state_next = r_state;
        if (bus.restart || !w_legal) begin
            w_state_next = INIT_VEC;
        end else if (bus.run) begin
            w_state_next = '0;
            if (r_state[S_INIT]) begin
                w_state_next[S_A1] = 1'b1;
            end
            for (int i = S_A1; i < S_CHKA; i++) begin
                if (r_state[i]) begin
                    w_state_next[i+1] = 1'b1;
                end
            end
            if (r_state[S_CHKA]) begin
                if (w_dec) begin
                    w_state_next[S_A1] = 1'b1;
                end else begin
                    w_state_next[S_B1] = 1'b1;
                end
            end
            for (int i = S_B1; i < S_CHKB; i++) begin
                if (r_state[i]) begin
                    w_state_next[i+1] = 1'b1;
                end
            end
            if (r_state[S_CHKB]) begin
                if (w_inc) begin
                    w_state_next[S_A1] = 1'b1;
                end else begin
                    w_state_next[S_C1] = 1'b1;
                end
            end
            for (int i = S_C1; i < S_CLAST; i++) begin
                if (r_state[i]) begin
                    w_state_next[i+1] = 1'b1;
                end
            end
            if (r_state[S_CLAST]) begin
                w_state_next[S_A1] = 1'b1;
            end
        end
    end

    // Register updates: only INIT, CHK_A and CHK_B touch X/Y, and err fires only on recovery.
    always_comb begin
        w_x_next   = r_x;
        w_y_next   = r_y;
        w_err_next = 1'b0;
        if (bus.restart) begin
            w_err_next = 1'b0;
        end else if (!w_legal) begin
            w_err_next = 1'b1;
        end else if (bus.run) begin
            if (r_state[S_INIT]) begin
                w_x_next = X_INIT;
                w_y_next = Y_INIT;
            end
            if (r_state[S_CHKA] && w_dec) begin
                w_y_next = w_y_dec;
            end
            if (r_state[S_CHKB] && w_inc) begin
                w_x_next = w_x_inc;
            end
        end
    end

    assign bus.x       = r_x;
    assign bus.y       = r_y;
    assign bus.state_o = r_state;
    assign bus.err     = r_err;

endmodule

// File: tb/tb_onehot_seq_fsm.sv
// Self-checking bench for onehot_seq_fsm.
// Three instances share clock and stimulus: defaults, saturating with near-limit
// init values, and wrapping with the same init values.
module tb_onehot_seq_fsm;

    localparam int NS       = 16;
    localparam int DA       = 6;
    localparam int DB       = 3;
    localparam int CHKA_POS = DA + 1;
    localparam int CHKB_POS = DA + DB + 2;
    localparam int MAXV     = 255;

    typedef struct {
        int pos;
        int x;
        int y;
        bit err;
    } model_t;

    typedef struct {
        bit        resetb;
        bit        restart;
        bit        run;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] expState;
        logic [7:0]  expX;
        logic [7:0]  expY;
        bit          expErr;
    } vec_t;

    logic       clk;
    logic       resetb;
    logic       run;
    logic       restart;
    logic [7:0] a;
    logic [7:0] b;

    int nChecks;
    int nFails;

    model_t m0;
    model_t m1;
    model_t m2;

    onehot_seq_fsm_if #(.WIDTH(8), .NS(NS)) bus0 ();
    onehot_seq_fsm_if #(.WIDTH(8), .NS(NS)) bus1 ();
    onehot_seq_fsm_if #(.WIDTH(8), .NS(NS)) bus2 ();

    assign bus0.run = run;  assign bus0.restart = restart;  assign bus0.a = a;  assign bus0.b = b;
    assign bus1.run = run;  assign bus1.restart = restart;  assign bus1.a = a;  assign bus1.b = b;
    assign bus2.run = run;  assign bus2.restart = restart;  assign bus2.a = a;  assign bus2.b = b;

    onehot_seq_fsm dut0 (
        .clk    (clk),
        .resetb (resetb),
        .bus    (bus0)
    );

    onehot_seq_fsm #(
        .X_INIT   (8'd254),
        .Y_INIT   (8'd2),
        .SATURATE (1'b1)
    ) dut1 (
        .clk    (clk),
        .resetb (resetb),
        .bus    (bus1)
    );

    onehot_seq_fsm #(
        .X_INIT   (8'd254),
        .Y_INIT   (8'd2),
        .SATURATE (1'b0)
    ) dut2 (
        .clk    (clk),
        .resetb (resetb),
        .bus    (bus2)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog so the run always ends.
    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    // Behavioural reference: the loop as an integer position plus integer X/Y arithmetic.
    function automatic model_t modelStep(model_t m, bit rb, bit rs, bit rn, int av, int bv,
                                         bit illegal, bit sat, int xinit, int yinit);
        model_t n;
        n     = m;
        n.err = 1'b0;
        if (!rb) begin
            n.pos = 0;
            n.x   = 0;
            n.y   = 0;
        end else if (rs) begin
            n.pos = 0;
        end else if (illegal) begin
            n.pos = 0;
            n.err = 1'b1;
        end else if (!rn) begin
            n.pos = m.pos;
        end else if (m.pos == 0) begin
            n.x   = xinit;
            n.y   = yinit;
            n.pos = 1;
        end else if (m.pos == CHKA_POS) begin
            if (av == 1) begin
                n.y   = (m.y == 0) ? (sat ? 0 : MAXV) : m.y - 1;
                n.pos = 1;
            end else begin
                n.pos = m.pos + 1;
            end
        end else if (m.pos == CHKB_POS) begin
            if (bv == 1) begin
                n.x   = (m.x == MAXV) ? (sat ? MAXV : 0) : m.x + 1;
                n.pos = 1;
            end else begin
                n.pos = m.pos + 1;
            end
        end else if (m.pos == NS - 1) begin
            n.pos = 1;
        end else begin
            n.pos = m.pos + 1;
        end
        return n;
    endfunction

    task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] req);
        nChecks++;
        if (act !== req) begin
            nFails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic checkOutput(input string tag, input model_t m, input logic [15:0] st,
                               input logic [7:0] xv, input logic [7:0] yv, input logic ev);
        logic [15:0] expSt;
        expSt = 16'h0001 << m.pos;
        checkValue({tag, ".state_o"}, 32'(st), 32'(expSt));
        checkValue({tag, ".x"},       32'(xv), 32'(m.x));
        checkValue({tag, ".y"},       32'(yv), 32'(m.y));
        checkValue({tag, ".err"},     32'(ev), 32'(m.err));
    endtask

    // One clock: advance the models at the edge, compare all instances on the falling edge.
    task automatic applyStimulus(input bit illegal0);
        @(posedge clk);
        m0 = modelStep(m0, resetb, restart, run, int'(a), int'(b), illegal0, 1'b1, 20, 100);
        m1 = modelStep(m1, resetb, restart, run, int'(a), int'(b), 1'b0, 1'b1, 254, 2);
        m2 = modelStep(m2, resetb, restart, run, int'(a), int'(b), 1'b0, 1'b0, 254, 2);
        @(negedge clk);
        checkOutput("dut0", m0, bus0.state_o, bus0.x, bus0.y, bus0.err);
        checkOutput("dut1", m1, bus1.state_o, bus1.x, bus1.y, bus1.err);
        checkOutput("dut2", m2, bus2.state_o, bus2.x, bus2.y, bus2.err);
    endtask

    // Plant an illegal vector in dut0 between edges and check the recovery.
    task automatic injectIllegal(input logic [15:0] badVec, input string tag);
        force dut0.r_state = badVec;
        #1;
        release dut0.r_state;
        applyStimulus(1'b1);
        checkValue({tag, ".recover_state"}, 32'(bus0.state_o), 32'h0001);
        checkValue({tag, ".recover_err"},   32'(bus0.err),     32'h1);
        applyStimulus(1'b0);
        checkValue({tag, ".err_cleared"},   32'(bus0.err),     32'h0);
        checkValue({tag, ".reload_x"},      32'(bus0.x),       32'd20);
        checkValue({tag, ".reload_y"},      32'(bus0.y),       32'd100);
    endtask

    initial begin
        vec_t vecs[8];
        nChecks = 0;
        nFails  = 0;
        m0      = '{pos: 0, x: 0, y: 0, err: 1'b0};
        m1      = m0;
        m2      = m0;
        resetb  = 1'b0;
        run     = 1'b1;
        restart = 1'b0;
        a       = 8'd0;
        b       = 8'd0;

        // resetb restart run a b | state x y err (dut0, defaults)
        vecs[0] = '{1'b0, 1'b0, 1'b1, 8'd0, 8'd0, 16'h0001, 8'd0,  8'd0,   1'b0};
        vecs[1] = '{1'b0, 1'b0, 1'b1, 8'd0, 8'd0, 16'h0001, 8'd0,  8'd0,   1'b0};
        vecs[2] = '{1'b1, 1'b0, 1'b1, 8'd0, 8'd0, 16'h0002, 8'd20, 8'd100, 1'b0};
        vecs[3] = '{1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 16'h0002, 8'd20, 8'd100, 1'b0};
        vecs[4] = '{1'b1, 1'b0, 1'b1, 8'd0, 8'd0, 16'h0004, 8'd20, 8'd100, 1'b0};
        vecs[5] = '{1'b1, 1'b1, 1'b0, 8'd0, 8'd0, 16'h0001, 8'd20, 8'd100, 1'b0};
        vecs[6] = '{1'b1, 1'b0, 1'b1, 8'd0, 8'd0, 16'h0002, 8'd20, 8'd100, 1'b0};
        vecs[7] = '{1'b1, 1'b0, 1'b1, 8'd0, 8'd0, 16'h0004, 8'd20, 8'd100, 1'b0};

        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            resetb  = vecs[i].resetb;
            restart = vecs[i].restart;
            run     = vecs[i].run;
            a       = vecs[i].a;
            b       = vecs[i].b;
            applyStimulus(1'b0);
            checkValue($sformatf("vec%0d.state_o", i), 32'(bus0.state_o), 32'(vecs[i].expState));
            checkValue($sformatf("vec%0d.x", i),       32'(bus0.x),       32'(vecs[i].expX));
            checkValue($sformatf("vec%0d.y", i),       32'(bus0.y),       32'(vecs[i].expY));
            checkValue($sformatf("vec%0d.err", i),     32'(bus0.err),     32'(vecs[i].expErr));
        end

        $display("[TB] idle loop, a=b=0");
        repeat (300) applyStimulus(1'b0);
        checkValue("idle.x", 32'(bus0.x), 32'd20);
        checkValue("idle.y", 32'(bus0.y), 32'd100);

        $display("[TB] a=1 from loop entry");
        restart = 1'b1;
        applyStimulus(1'b0);
        restart = 1'b0;
        applyStimulus(1'b0);
        a = 8'd1;
        repeat (70) applyStimulus(1'b0);
        checkValue("dec70.dut0_y",     32'(bus0.y),       32'd90);
        checkValue("dec70.dut0_x",     32'(bus0.x),       32'd20);
        checkValue("dec70.dut0_state", 32'(bus0.state_o), 32'h0002);
        checkValue("dec70.sat_y",      32'(bus1.y),       32'd0);
        checkValue("dec70.wrap_y",     32'(bus2.y),       32'd248);

        $display("[TB] b=1 only");
        a = 8'd0;
        b = 8'd1;
        repeat (44) applyStimulus(1'b0);
        checkValue("inc44.dut0_x", 32'(bus0.x), 32'd24);
        checkValue("inc44.dut0_y", 32'(bus0.y), 32'd90);
        checkValue("inc44.sat_x",  32'(bus1.x), 32'd255);
        checkValue("inc44.wrap_x", 32'(bus2.x), 32'd2);

        $display("[TB] a=b=1, CHK_A wins");
        a = 8'd1;
        repeat (14) applyStimulus(1'b0);
        checkValue("both.dut0_x", 32'(bus0.x), 32'd24);
        checkValue("both.dut0_y", 32'(bus0.y), 32'd88);

        $display("[TB] hold mid A-chain, then restart while held");
        a = 8'd0;
        b = 8'd0;
        repeat (3) applyStimulus(1'b0);
        run = 1'b0;
        repeat (10) applyStimulus(1'b0);
        checkValue("hold.state", 32'(bus0.state_o), 32'h0010);
        restart = 1'b1;
        applyStimulus(1'b0);
        checkValue("restart_held.state", 32'(bus0.state_o), 32'h0001);
        restart = 1'b0;
        run     = 1'b1;
        applyStimulus(1'b0);

        $display("[TB] reset mid loop");
        repeat (20) applyStimulus(1'b0);
        resetb = 1'b0;
        applyStimulus(1'b0);
        checkValue("midreset.state", 32'(bus0.state_o), 32'h0001);
        checkValue("midreset.x",     32'(bus0.x),       32'd0);
        checkValue("midreset.y",     32'(bus0.y),       32'd0);
        resetb = 1'b1;
        applyStimulus(1'b0);

        $display("[TB] illegal state recovery");
        repeat (5) applyStimulus(1'b0);
        injectIllegal(16'h0003, "multihot");
        repeat (3) applyStimulus(1'b0);
        injectIllegal(16'h0000, "allzero");

        $display("[TB] randomized stimulus");
        for (int i = 0; i < 1500; i++) begin
            resetb  = ($urandom_range(0, 99) != 0);
            restart = ($urandom_range(0, 39) == 0);
            run     = ($urandom_range(0, 7) != 0);
            case ($urandom_range(0, 3))
                0:       a = 8'd0;
                1, 2:    a = 8'd1;
                default: a = 8'($urandom);
            endcase
            case ($urandom_range(0, 3))
                0:       b = 8'd0;
                1, 2:    b = 8'd1;
                default: b = 8'($urandom);
            endcase
            applyStimulus(1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
